// File: rtl/irq_encoder4_2.sv
// ---------------------------------------------------------------------------
// irq_encoder4_2
//
// Sequential 4-to-2 priority encoder used as the interrupt/exception source
// encoder in front of the single-cycle MIPS control path.
//
// Rising edges on the request lines are captured into a pending vector. The
// index of the highest pending line is presented on code/valid. The consumer
// retires the presented event with ack. Every accepted ack advances a
// wrapping counter.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   in         in   NIN    request lines (level); an event is a 0->1 change
//   ack        in   1      retire the currently presented code
//   code       out  ENC_W  index of the highest pending bit (bit NIN-1 wins)
//   valid      out  1      any pending bit set
//   multi      out  1      two or more pending bits set
//   lost       out  1      sticky: an event hit a line that was still pending
//   ack_count  out  CNT_W  accepted acks, modulo 2**CNT_W
// ---------------------------------------------------------------------------
module irq_encoder4_2 #(
    parameter int NIN   = 4,
    parameter int ENC_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NIN-1:0]   in,
    input  logic             ack,
    output logic [ENC_W-1:0] code,
    output logic             valid,
    output logic             multi,
    output logic             lost,
    output logic [CNT_W-1:0] ack_count
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NIN-1:0]   in_q_reg;
    logic [NIN-1:0]   pending_reg;
    logic             lost_reg;
    logic [CNT_W-1:0] ack_count_reg;

    // ------------------------------------------------------------------
    // Next-state terms
    // ------------------------------------------------------------------
    logic [NIN-1:0]   rise;          // 0->1 transitions seen this cycle
    logic             accept;        // ack that actually retires something
    logic [NIN-1:0]   clr;           // one-hot retire mask
    logic [NIN-1:0]   pending_next;
    logic [NIN-1:0]   lost_hit;      // per-line overflow this cycle
    logic             lost_next;
    logic [CNT_W-1:0] ack_count_next;

    // Decoded view of the registered pending vector
    logic [ENC_W-1:0] code_enc;
    logic             valid_enc;
    logic             multi_enc;

    // ------------------------------------------------------------------
    // Priority encode. Outputs depend on pending_reg only, so there is no
    // combinational path from in or ack to code/valid/multi.
    // Scanning upward lets the highest set index overwrite lower ones.
    // ------------------------------------------------------------------
    always_comb begin
        code_enc = '0;
        for (int i = 0; i < NIN; i++) begin
            if (pending_reg[i]) begin
                code_enc = ENC_W'(i);
            end
        end
    end

    assign valid_enc = |pending_reg;

    // Clearing the lowest set bit leaves something only if two or more
    // bits were set.
    assign multi_enc = |(pending_reg & (pending_reg - NIN'(1)));

    // An ack while nothing is presented is ignored entirely.
    assign accept = ack & valid_enc;

    assign rise = in & ~in_q_reg;

    // ------------------------------------------------------------------
    // Per-line retire / capture / overflow logic
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_line
            // Retire only the line currently being presented.
            assign clr[gi] = accept & (code_enc == ENC_W'(gi));

            // Set wins over clear: a fresh edge on the line being retired
            // keeps it pending as a new event.
            assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | rise[gi];

            // A new edge on a line that is pending and not being retired
            // collapses two events into one.
            assign lost_hit[gi] = rise[gi] & pending_reg[gi] & ~clr[gi];
        end
    endgenerate

    assign lost_next      = lost_reg | (|lost_hit);
    assign ack_count_next = accept ? (ack_count_reg + CNT_W'(1)) : ack_count_reg;

    // ------------------------------------------------------------------
    // Registers. in_q resets to 0 so a line already high when reset is
    // released yields exactly one event on the first clock.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q_reg      <= '0;
            pending_reg   <= '0;
            lost_reg      <= 1'b0;
            ack_count_reg <= '0;
        end else begin
            in_q_reg      <= in;
            pending_reg   <= pending_next;
            lost_reg      <= lost_next;
            ack_count_reg <= ack_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign code      = code_enc;
    assign valid     = valid_enc;
    assign multi     = multi_enc;
    assign lost      = lost_reg;
    assign ack_count = ack_count_reg;

endmodule

// File: doc/irq_encoder4_2.md
Name: irq_encoder4_2

Overview:
- Sequential 4-to-2 priority encoder; the inverse of the 2-to-4 one-hot decoder.
- Captures rising edges on four request lines into a pending register and presents the encoded index of the highest-priority pending line.
- A valid/ack handshake retires each event.
- Serves as the interrupt/exception source encoder feeding the single-cycle MIPS control path.

Parameters:
- NIN, 4, number of request lines. Fixed at 4 for this revision.
- ENC_W, 2, encoded output width, log2(NIN).
- CNT_W, 8, width of the serviced-event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  4  request lines, level inputs; an event is a 0->1 transition.
- ack  input  1  consumer retires the currently presented code.
- code  output  2  index of the highest-set pending bit. Bit 3 has highest priority.
- valid  output  1  high when any pending bit is set.
- multi  output  1  high when two or more pending bits are set.
- lost  output  1  sticky overflow flag.
- ack_count  output  8  number of accepted acks, modulo 256.

Behaviour:
- State: in_q[3:0] (previous input sample), pending[3:0], lost, ack_count[7:0].
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - in_q=0, pending=0, lost=0, ack_count=0.
  - Outputs therefore code=0, valid=0, multi=0, lost=0, ack_count=0.
- Edge detect: edge = in & ~in_q. in_q <= in every cycle.
  - Because in_q resets to 0, a line already high when reset is released produces exactly one event on the first clock.
- Ack acceptance: accept = ack & valid. ack while valid=0 is ignored; nothing changes and the counter does not move.
- Retire mask: clr = one-hot(code) when accept, else 0.
- Pending update: pending <= (pending & ~clr) | edge.
  - If a new edge and the retire hit the same bit in the same cycle, set wins: the bit stays pending and is treated as a new event.
- code, valid and multi are combinational decodes of the registered pending vector only; in and ack have no combinational path to them.
  - code: pending 1xxx->3, 01xx->2, 001x->1, 0001->0. When pending=0, code=0.
  - valid = |pending.
  - multi = high when pending has two or more bits set.
- Latency: an input rise sampled at clock edge k gives valid/code updated immediately after edge k (1 cycle).
  - After an accepted ack at edge k, the next-priority code appears after edge k.
- Retire order: code changes only when the pending vector changes. A higher-priority edge arriving while a lower code is presented preempts it; the next accepted ack retires the higher one.
- lost: set when edge[i] & pending[i] & ~clr[i] for any i, meaning an event arrived on a line that is already pending and not being retired. Cleared only by reset.
- ack_count <= ack_count + 1 on each accepted ack. Wraps 255->0 with no flag.
- A line held high produces one event only. It must go low for at least one sampled cycle before it can generate another.

Test Plan:
- Reset/idle:
  - Assert reset with in=4'b0000, then release → code=0, valid=0, multi=0, lost=0, ack_count=0.
  - Assert reset asynchronously between clock edges while pending=4'b0110 → all outputs 0 immediately.
- Single events, mirroring the decoder vectors: pulse in=1, 2, 4, 8 one at a time, each followed by ack=1 for one cycle.
  - Expected codes 0, 1, 2, 3, each with valid=1 one cycle after the rise.
  - After each ack, valid=0; after all four, ack_count=4.
- Priority/multi: raise in=4'b0101 in one cycle.
  - Expect code=2, multi=1.
  - After ack: code=0, multi=0, valid=1.
  - After a second ack: valid=0, ack_count=2.
- Set-vs-clear collision: with pending=4'b1000, code=3, pulse in[3] low for one cycle, then high again in the same cycle as ack.
  - pending[3] stays 1, valid=1, ack_count increments, lost=0.
- Overflow: with pending[1]=1 and no ack, drop in[1] then raise it again → lost=1. lost stays 1 after all events are acked, and clears only on reset.
- Counter wrap/spurious ack:
  - ack with valid=0 → ack_count unchanged.
  - Service 256 events → ack_count returns to 0.
  - A line held high for 10 cycles counts as 1 event.
